// File: rtl/tcdm_banks_pipe.sv
// Parity-protected TCDM bank array with boot zero-fill and a
// configurable read pipeline; one request port per bank.
module tcdm_banks_pipe #(
  parameter int unsigned NbBanks     = 16,
  parameter int unsigned BankSize    = 256,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned IdWidth     = 1,
  parameter int unsigned Latency     = 1,
  parameter int unsigned ErrCntWidth = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           test_mode_i,
  input  logic [NbBanks-1:0]             req_i,
  output logic [NbBanks-1:0]             gnt_o,
  input  logic [NbBanks-1:0]             wen_i,
  input  logic [NbBanks*AddrWidth-1:0]   add_i,
  input  logic [NbBanks*DataWidth-1:0]   data_i,
  input  logic [NbBanks*DataWidth/8-1:0] be_i,
  input  logic [NbBanks*IdWidth-1:0]     id_i,
  output logic [NbBanks-1:0]             r_valid_o,
  output logic [NbBanks*DataWidth-1:0]   r_data_o,
  output logic [NbBanks*IdWidth-1:0]     r_id_o,
  output logic [NbBanks-1:0]             r_err_o,
  output logic [ErrCntWidth-1:0]         err_cnt_o,
  input  logic                           err_clr_i,
  output logic                           init_done_o
);

  localparam int unsigned NbBytes = DataWidth / 8;
  localparam int unsigned WordW   = DataWidth + NbBytes;
  localparam int unsigned IdxW    = $clog2(BankSize);
  localparam int unsigned SumW    = ErrCntWidth + $clog2(NbBanks + 1);
  localparam int unsigned Last    = Latency - 1;
  localparam logic [IdxW-1:0] LastW = IdxW'(BankSize - 1);

  typedef enum logic {INIT, RUN} state_e;

  state_e           state_q;
  logic             boot_q;
  logic             run_q;
  logic [IdxW-1:0]  w_q;
  logic             skip_fill;
  logic             init_we;

  assign skip_fill = boot_q & test_mode_i;
  assign init_we   = (state_q == INIT) & ~skip_fill;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= INIT;
      boot_q  <= 1'b1;
      run_q   <= 1'b0;
      w_q     <= '0;
    end else begin
      boot_q <= 1'b0;
      unique case (state_q)
        INIT: begin
          if (skip_fill || w_q == LastW) begin
            state_q <= RUN;
            run_q   <= 1'b1;
          end else begin
            w_q <= w_q + 1'b1;
          end
        end
        RUN: begin
          run_q <= 1'b1;
        end
      endcase
    end
  end

  assign gnt_o       = {NbBanks{run_q}};
  assign init_done_o = run_q;

  logic [NbBanks-1:0] acc;
  logic [NbBanks-1:0] rd_acc;
  logic [NbBanks-1:0] wr_acc;
  logic [IdxW-1:0]    idx [NbBanks];

  // Only the word-index bits of the byte address matter.
  always_comb begin
    for (int b = 0; b < NbBanks; b++) begin
      idx[b] = add_i[b*AddrWidth+2 +: IdxW];
    end
    acc    = req_i & {NbBanks{run_q}};
    rd_acc = acc & wen_i;
    wr_acc = acc & ~wen_i;
  end

  logic unused_add;
  assign unused_add = ^add_i;

  // Word layout: {parity[NbBytes-1:0], data[DataWidth-1:0]}.
  logic [WordW-1:0] mem [NbBanks][BankSize];

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NbBanks; b++) begin
      if (init_we) begin
        mem[b][w_q] <= '0;
      end else if (wr_acc[b]) begin
        for (int j = 0; j < NbBytes; j++) begin
          if (be_i[b*NbBytes+j]) begin
            mem[b][idx[b]][j*8 +: 8] <=
              data_i[b*DataWidth+j*8 +: 8];
            mem[b][idx[b]][DataWidth+j] <=
              ^data_i[b*DataWidth+j*8 +: 8];
          end
        end
      end
    end
  end

  logic [NbBanks-1:0]         vld_q  [Latency];
  logic [NbBanks-1:0]         rd_q   [Latency];
  logic [NbBanks*IdWidth-1:0] id_q   [Latency];
  logic [WordW-1:0]           word_q [Latency][NbBanks];

  // Stage 0 is the SRAM output; later stages only advance on a response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < Latency; k++) begin
        vld_q[k] <= '0;
        rd_q[k]  <= '0;
        id_q[k]  <= '0;
        for (int b = 0; b < NbBanks; b++) begin
          word_q[k][b] <= '0;
        end
      end
    end else begin
      vld_q[0] <= acc;
      for (int b = 0; b < NbBanks; b++) begin
        if (acc[b]) begin
          rd_q[0][b] <= wen_i[b];
          id_q[0][b*IdWidth +: IdWidth] <=
            id_i[b*IdWidth +: IdWidth];
        end
        if (rd_acc[b]) begin
          word_q[0][b] <= mem[b][idx[b]];
        end
      end
      for (int k = 1; k < Latency; k++) begin
        vld_q[k] <= vld_q[k-1];
        for (int b = 0; b < NbBanks; b++) begin
          if (vld_q[k-1][b]) begin
            rd_q[k][b] <= rd_q[k-1][b];
            id_q[k][b*IdWidth +: IdWidth] <=
              id_q[k-1][b*IdWidth +: IdWidth];
            if (rd_q[k-1][b]) begin
              word_q[k][b] <= word_q[k-1][b];
            end
          end
        end
      end
    end
  end

  logic [NbBanks-1:0] fail;

  always_comb begin
    fail      = '0;
    r_valid_o = vld_q[Last];
    r_id_o    = id_q[Last];
    r_data_o  = '0;
    for (int b = 0; b < NbBanks; b++) begin
      r_data_o[b*DataWidth +: DataWidth] =
        word_q[Last][b][DataWidth-1:0];
      for (int j = 0; j < NbBytes; j++) begin
        fail[b] = fail[b] |
          (^{word_q[Last][b][j*8 +: 8],
             word_q[Last][b][DataWidth+j]});
      end
    end
    r_err_o = rd_q[Last] & fail;
  end

  logic [SumW-1:0]        sum;
  logic [ErrCntWidth-1:0] err_cnt_q;

  always_comb begin
    sum = err_clr_i ? '0 : SumW'(err_cnt_q);
    for (int b = 0; b < NbBanks; b++) begin
      sum = sum + SumW'(r_valid_o[b] & r_err_o[b]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_q <= '0;
    end else if (|sum[SumW-1:ErrCntWidth]) begin
      err_cnt_q <= '1;
    end else begin
      err_cnt_q <= sum[ErrCntWidth-1:0];
    end
  end

  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_tcdm_banks_pipe.sv
// Scoreboard bench for tcdm_banks_pipe: a word/parity reference model
// queues expected responses, a negedge monitor retires them.
module tb_tcdm_banks_pipe;
  localparam int NB  = 16;
  localparam int BS  = 256;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int IDW = 1;
  localparam int LAT = 2;
  localparam int ECW = 2;
  localparam int NBY = DW / 8;
  localparam int IXW = $clog2(BS);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic test_mode = 1'b0;
  logic clr = 1'b0;
  logic [NB-1:0]     req = '0;
  logic [NB-1:0]     wen = '0;
  logic [NB*AW-1:0]  add = '0;
  logic [NB*DW-1:0]  wdata = '0;
  logic [NB*NBY-1:0] be = '0;
  logic [NB*IDW-1:0] id = '0;
  logic [NB-1:0]     gnt;
  logic [NB-1:0]     r_valid;
  logic [NB*DW-1:0]  r_data;
  logic [NB*IDW-1:0] r_id;
  logic [NB-1:0]     r_err;
  logic [ECW-1:0]    err_cnt;
  logic              init_done;

  tcdm_banks_pipe #(
    .NbBanks(NB), .BankSize(BS), .DataWidth(DW), .AddrWidth(AW),
    .IdWidth(IDW), .Latency(LAT), .ErrCntWidth(ECW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .test_mode_i(test_mode),
    .req_i(req), .gnt_o(gnt), .wen_i(wen), .add_i(add),
    .data_i(wdata), .be_i(be), .id_i(id),
    .r_valid_o(r_valid), .r_data_o(r_data), .r_id_o(r_id),
    .r_err_o(r_err), .err_cnt_o(err_cnt), .err_clr_i(clr),
    .init_done_o(init_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    int             due;
    logic           rd;
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
    logic           err;
  } exp_t;

  typedef struct packed {
    int b;
    int w;
    int bt;
  } flip_t;

  exp_t  sbq [NB][$];
  flip_t fq[$];

  logic [DW-1:0]  ref_data [NB][BS];
  logic [NBY-1:0] ref_bad  [NB][BS];

  logic [NB-1:0]     s_req = '0;
  logic [NB-1:0]     s_wen = '0;
  logic [NB*AW-1:0]  s_add = '0;
  logic [NB*DW-1:0]  s_data = '0;
  logic [NB*NBY-1:0] s_be = '0;
  logic [NB*IDW-1:0] s_id = '0;
  logic              s_clr = 1'b0;

  task automatic zero_ref();
    for (int b = 0; b < NB; b++)
      for (int w = 0; w < BS; w++) begin
        ref_data[b][w] = '0;
        ref_bad[b][w]  = '0;
      end
  endtask

  task automatic set_rd(input int b, input logic [AW-1:0] a,
                        input logic [IDW-1:0] i);
    s_req[b] = 1'b1;
    s_wen[b] = 1'b1;
    s_add[b*AW +: AW] = a;
    s_id[b*IDW +: IDW] = i;
  endtask

  task automatic set_wr(input int b, input logic [AW-1:0] a,
                        input logic [DW-1:0] d,
                        input logic [NBY-1:0] m,
                        input logic [IDW-1:0] i);
    s_req[b] = 1'b1;
    s_wen[b] = 1'b0;
    s_add[b*AW +: AW] = a;
    s_data[b*DW +: DW] = d;
    s_be[b*NBY +: NBY] = m;
    s_id[b*IDW +: IDW] = i;
  endtask

  // One clock: apply pending bit flips, drive staged requests, and
  // record what each accepted request must return LAT cycles later.
  task automatic step();
    flip_t f;
    exp_t e;
    int w;
    logic [DW+NBY-1:0] m;
    @(posedge clk);
    #1;
    while (fq.size() > 0) begin
      f = fq.pop_front();
      m = '0;
      m[f.bt] = 1'b1;
      dut.mem[f.b][f.w] <= dut.mem[f.b][f.w] ^ m;
      ref_data[f.b][f.w][f.bt] = ~ref_data[f.b][f.w][f.bt];
      ref_bad[f.b][f.w][f.bt/8] = ~ref_bad[f.b][f.w][f.bt/8];
    end
    req = s_req;
    wen = s_wen;
    add = s_add;
    wdata = s_data;
    be = s_be;
    id = s_id;
    clr = s_clr;
    for (int b = 0; b < NB; b++) begin
      if (s_req[b]) begin
        w = int'(s_add[b*AW+2 +: IXW]);
        e.due = cyc + LAT;
        e.rd = s_wen[b];
        e.id = s_id[b*IDW +: IDW];
        if (s_wen[b]) begin
          e.data = ref_data[b][w];
          e.err = |ref_bad[b][w];
        end else begin
          for (int j = 0; j < NBY; j++)
            if (s_be[b*NBY+j]) begin
              ref_data[b][w][j*8 +: 8] = s_data[b*DW+j*8 +: 8];
              ref_bad[b][w][j] = 1'b0;
            end
          e.data = '0;
          e.err = 1'b0;
        end
        sbq[b].push_back(e);
      end
    end
    s_req = '0;
    s_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  logic [ECW-1:0] exp_cnt = '0;

  always @(negedge clk) begin
    int nerr;
    int sum;
    exp_t e;
    logic exp_v;
    nerr = 0;
    if (!rst_n) exp_cnt = '0;
    for (int b = 0; b < NB; b++) begin
      exp_v = (sbq[b].size() > 0) && (sbq[b][0].due == cyc);
      chk($sformatf("valid[%0d]", b), 64'(r_valid[b]), 64'(exp_v));
      if (exp_v) begin
        e = sbq[b].pop_front();
        chk($sformatf("id[%0d]", b), 64'(r_id[b*IDW +: IDW]),
            64'(e.id));
        if (e.rd) begin
          chk($sformatf("data[%0d]", b), 64'(r_data[b*DW +: DW]),
              64'(e.data));
          chk($sformatf("err[%0d]", b), 64'(r_err[b]), 64'(e.err));
          if (e.err) nerr++;
        end else begin
          chk($sformatf("wr_err[%0d]", b), 64'(r_err[b]), 64'(0));
        end
      end
    end
    chk("err_cnt", 64'(err_cnt), 64'(exp_cnt));
    if (rst_n) begin
      sum = (clr ? 0 : int'(exp_cnt)) + nerr;
      exp_cnt = (sum > (1 << ECW) - 1) ? '1 : ECW'(sum);
    end
  end

  task automatic wait_init(input int exp_len);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (&gnt) done = 1'b1;
      else n++;
    end
    chk("init_len", 64'(n), 64'(exp_len));
    chk("init_done", 64'(init_done), 64'(1));
    zero_ref();
  endtask

  initial begin
    int tot;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_valid", 64'(r_valid), 64'(0));
    chk("rst_id", 64'(r_id), 64'(0));
    chk("rst_err", 64'(r_err), 64'(0));
    chk("rst_data", 64'(|r_data), 64'(0));
    chk("rst_cnt", 64'(err_cnt), 64'(0));
    chk("rst_done", 64'(init_done), 64'(0));
    rst_n = 1'b1;
    wait_init(BS);

    set_rd(0, 32'(255*4), 1'b0);
    step();
    set_wr(3, 32'(5*4), 32'hDEADBEEF, 4'hF, 1'b1);
    step();
    set_rd(3, 32'(5*4), 1'b0);
    step();
    set_wr(3, 32'(5*4), 32'h0000CAFE, 4'h3, 1'b0);
    step();
    set_rd(3, 32'h8000_0417, 1'b1);
    step();
    idle(LAT + 1);

    fq.push_back('{b: 2, w: 9, bt: 4});
    fq.push_back('{b: 7, w: 9, bt: 17});
    idle(1);
    set_rd(2, 32'(9*4), 1'b1);
    set_rd(7, 32'(9*4), 1'b0);
    idle(LAT + 2);
    chk("cnt_two", 64'(err_cnt), 64'(2));
    set_rd(2, 32'(9*4), 1'b0);
    set_rd(7, 32'(9*4), 1'b1);
    step();
    step();
    s_clr = 1'b1;
    step();
    step();
    chk("cnt_clr_hit", 64'(err_cnt), 64'(2));
    set_rd(2, 32'(9*4), 1'b0);
    set_rd(7, 32'(9*4), 1'b0);
    idle(LAT + 2);
    chk("cnt_sat", 64'(err_cnt), 64'(3));
    s_clr = 1'b1;
    idle(2);
    chk("cnt_clr", 64'(err_cnt), 64'(0));

    for (int c = 0; c < 50; c++) begin
      for (int b = 0; b < NB; b++)
        set_rd(b, $urandom(), IDW'($urandom_range(1)));
      step();
    end
    idle(LAT + 1);

    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < NB; b++) begin
        if ($urandom_range(3) != 0) begin
          if ($urandom_range(1) == 1)
            set_rd(b, $urandom(), IDW'($urandom_range(1)));
          else
            set_wr(b, $urandom(), $urandom(),
                   NBY'($urandom_range(15)), IDW'($urandom_range(1)));
        end
      end
      if ($urandom_range(7) == 0)
        fq.push_back('{b: $urandom_range(NB-1),
                       w: $urandom_range(BS-1),
                       bt: $urandom_range(DW-1)});
      s_clr = ($urandom_range(9) == 0);
      step();
    end
    idle(LAT + 1);

    set_wr(5, 32'(7*4), 32'h12345678, 4'hF, 1'b0);
    set_wr(1, 32'(0), 32'hAABBCCDD, 4'hF, 1'b1);
    idle(LAT + 2);

    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("mid_init_gnt", 64'(gnt), 64'(0));
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_init(BS);
    set_rd(5, 32'(7*4), 1'b1);
    set_rd(3, 32'(5*4), 1'b0);
    step();
    set_wr(5, 32'(7*4), 32'h12345678, 4'hF, 1'b0);
    set_wr(1, 32'(0), 32'hAABBCCDD, 4'hF, 1'b1);
    idle(LAT + 2);

    test_mode = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("tm_gnt", 64'(gnt), 64'({NB{1'b1}}));
    chk("tm_done", 64'(init_done), 64'(1));
    test_mode = 1'b0;
    set_rd(5, 32'(7*4), 1'b1);
    set_rd(1, 32'(0), 1'b0);
    step();
    idle(LAT + 3);

    tot = 0;
    for (int b = 0; b < NB; b++) tot += sbq[b].size();
    chk("sb_empty", 64'(tot), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
